switch_debouncer: RTL

- Conditions the raw slide-switch inputs before they reach the 8-bit switches PIO of the Nios system (feeds switches_export directly).
- Per bit: 2-FF synchronizer, then a stability counter. Outputs a clean, glitch-free level plus single-cycle rise/fall pulses for downstream logic.
- Sits in the top level between the board switch pins and the Qsys system, in the clk_clk domain.

---
 rtl/switch_debouncer_pkg.sv | 25 ++
 rtl/switch_debouncer_deb_bit.sv | 80 ++++++++
 rtl/switch_debouncer.sv | 88 ++++++++
 3 files changed

// File: rtl/switch_debouncer_pkg.sv
// rtl/switch_debouncer_pkg.sv - shared defaults and cycle-count helper for the switch debouncer
//
// Contents:
//   SW_WIDTH_DEF     default number of switch bits
//   CLK_HZ_DEF       default clk_clk frequency
//   DEBOUNCE_MS_DEF  default debounce window in milliseconds
//   stable_cycles()  converts a clock rate and a window in ms into a cycle count
package switch_debouncer_pkg;

  localparam int SW_WIDTH_DEF    = 8;
  localparam int CLK_HZ_DEF      = 50_000_000;
  localparam int DEBOUNCE_MS_DEF = 10;

  // Divide first so large clock rates do not overflow a 32-bit int.
  // Clamped to 1 because a zero-cycle window has no meaning for the counter.
  function automatic int stable_cycles(input int clk_hz, input int ms);
    int cycles;
    cycles = (clk_hz / 1000) * ms;
    if (cycles < 1) begin
      cycles = 1;
    end
    return cycles;
  endfunction

endpackage

// File: rtl/switch_debouncer_deb_bit.sv
// rtl/switch_debouncer_deb_bit.sv - one switch bit: 2-FF synchronizer, stability counter, level and edge pulses
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   raw      in   asynchronous switch pin
//   stable   out  debounced level
//   rise     out  one-cycle pulse, coincident with stable going 0->1
//   fall     out  one-cycle pulse, coincident with stable going 1->0
//   update   out  combinational: stable changes on the coming edge
module deb_bit
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = stable_cycles(CLK_HZ_DEF, DEBOUNCE_MS_DEF),
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic update
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    sync0_d  = raw;
    sync1_d  = sync0_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;

    if (sync1_q == stable_q) begin
      // Agreement (or a glitch returning) restarts the window.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Counting from zero, this is the STABLE_CYCLES-th differing edge.
      stable_d = sync1_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Pulses are registered alongside stable_q so they line up with the new level.
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync0_q  <= sync0_d;
      sync1_q  <= sync1_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign update = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounces the board slide switches ahead of the switches PIO
//
// Optional feature macro: SWITCH_DEBOUNCER_EVENT_LATCH_EN (adds event_clr / event_flags).
//
// Ports:
//   clk_clk        in   system clock (Nios clock domain)
//   reset_reset_n  in   asynchronous active-low reset
//   sw_raw         in   asynchronous switch pins, WIDTH bits
//   sw_stable      out  debounced level, drives switches_export
//   sw_rise        out  per-bit one-cycle pulse on sw_stable 0->1
//   sw_fall        out  per-bit one-cycle pulse on sw_stable 1->0
//   any_change     out  one-cycle pulse, OR of sw_rise | sw_fall
//   event_clr      in   (macro only) clears event_flags on the next edge
//   event_flags    out  (macro only) sticky per-bit change flags
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH_DEF,
  parameter int STABLE_CYCLES = stable_cycles(CLK_HZ_DEF, DEBOUNCE_MS_DEF),
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
`ifdef SWITCH_DEBOUNCER_EVENT_LATCH_EN
  ,
  input  logic             event_clr,
  output logic [WIDTH-1:0] event_flags
`endif
);

  logic [WIDTH-1:0] update;
  logic             any_change_q, any_change_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    deb_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_deb_bit (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .raw   (sw_raw[i]),
      .stable(sw_stable[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i]),
      .update(update[i])
    );
  end

  // Built from the per-bit next-state so it lands in the same cycle as the pulses.
  always_comb begin
    any_change_d = |update;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= any_change_d;
    end
  end

  assign any_change = any_change_q;

`ifdef SWITCH_DEBOUNCER_EVENT_LATCH_EN
  logic [WIDTH-1:0] event_flags_q, event_flags_d;

  // A pulse arriving with event_clr still sets its bit: clear first, then OR in.
  always_comb begin
    event_flags_d = (event_clr ? '0 : event_flags_q) | sw_rise | sw_fall;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      event_flags_q <= '0;
    end else begin
      event_flags_q <= event_flags_d;
    end
  end

  assign event_flags = event_flags_q;
`endif

endmodule
